// File: rtl/line_buffer_taps.sv
// Multi-tap line delay: each accepted pixel leaves with taps_p-1 older pixels spaced delay_r apart.
// Latency: one cycle from accept to valid_o; full throughput through a one-entry output register.
// Backpressure: ready_o = ~valid_o | ready_i, forced low during reset and flush; output holds while stalled.
module line_buffer_taps #(
  parameter int width_p     = 8,
  parameter int max_delay_p = 640,
  parameter int taps_p      = 3
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               flush_i,
  input  logic [$clog2(max_delay_p+1)-1:0]   delay_i,
  input  logic [width_p-1:0]                 data_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  output logic                               valid_o,
  output logic [taps_p*width_p-1:0]          data_o,
  input  logic                               ready_i,
  output logic                               primed_o
);

  localparam int dw_lp   = $clog2(max_delay_p+1);
  localparam int aw_lp   = $clog2(max_delay_p);
  localparam int fw_lp   = $clog2((taps_p-1)*max_delay_p+1);
  localparam int nram_lp = taps_p-1;

  logic [dw_lp-1:0]              delay_r;
  logic [aw_lp-1:0]              wr_ptr;
  logic [aw_lp-1:0]              pend_addr;
  logic                          pend_vld;
  logic [fw_lp-1:0]              fill;
  logic [fw_lp-1:0]              fill_max;
  logic [fw_lp-1:0]              fill_nxt;
  logic                          accept;
  logic [width_p-1:0]            tap0_r;
  logic                          hit_r;
  logic [nram_lp-1:0]            mask_r;   // bit k-1 zeroes tap k
  logic [taps_p-1:0][width_p-1:0] tap_w;

  function automatic logic [dw_lp-1:0] clamp_delay(input logic [dw_lp-1:0] d);
    if (d == '0)
      return dw_lp'(1);
    else if (d > dw_lp'(max_delay_p))
      return dw_lp'(max_delay_p);
    else
      return d;
  endfunction

  assign ready_o  = ~reset_i & ~flush_i & (~valid_o | ready_i);
  assign accept   = valid_i & ready_o;
  assign fill_max = fw_lp'(nram_lp) * fw_lp'(delay_r);
  assign fill_nxt = (fill >= fill_max) ? fill_max : fill + fw_lp'(1);

  // Control state: line length, shared write pointer, fill level and output handshake.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      delay_r   <= clamp_delay(delay_i);
      wr_ptr    <= '0;
      pend_addr <= '0;
      pend_vld  <= 1'b0;
      fill      <= '0;
      valid_o   <= 1'b0;
      primed_o  <= 1'b0;
    end else if (flush_i) begin
      delay_r  <= clamp_delay(delay_i);
      wr_ptr   <= '0;
      pend_vld <= 1'b0;
      fill     <= '0;
      primed_o <= 1'b0;
      if (ready_i) valid_o <= 1'b0;
    end else if (accept) begin
      wr_ptr    <= (dw_lp'(wr_ptr) == delay_r - dw_lp'(1)) ? '0 : wr_ptr + aw_lp'(1);
      pend_addr <= wr_ptr;
      pend_vld  <= 1'b1;
      fill      <= fill_nxt;
      primed_o  <= (fill_nxt == fill_max);
      valid_o   <= 1'b1;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

  // Output-side registers: current pixel, per-tap masks from the pre-accept fill, and forward-hit flag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tap0_r <= '0;
      mask_r <= '1;
      hit_r  <= 1'b0;
    end else if (accept) begin
      tap0_r <= data_i;
      hit_r  <= pend_vld && (pend_addr == wr_ptr);
      for (int k = 1; k < taps_p; k++)
        mask_r[k-1] <= fill < (fw_lp'(k) * fw_lp'(delay_r));
    end
  end

  assign tap_w[0] = tap0_r;

  // Tap k's value only exists after its RAM read completes, so the previous beat's
  // taps (still on data_o) are written one accept late at the previous address.
  // With a one-pixel line that address is read on the same edge, hence the forward path.
  for (genvar k = 1; k < taps_p; k++) begin : g_tap
    logic [width_p-1:0] mem [max_delay_p];
    logic [width_p-1:0] rd_q;
    logic [width_p-1:0] fwd_q;

    // Sync-read RAM with deferred write; contents are never reset, masking hides stale data.
    always_ff @(posedge clk_i) begin
      if (accept) begin
        if (pend_vld) mem[pend_addr] <= tap_w[k-1];
        rd_q  <= mem[wr_ptr];
        fwd_q <= tap_w[k-1];
      end
    end

    assign tap_w[k] = mask_r[k-1] ? '0 : (hit_r ? fwd_q : rd_q);
  end

  assign data_o = tap_w;

endmodule

// File: tb/tb_line_buffer_taps.sv
module tb_line_buffer_taps;

  localparam int W    = 8;
  localparam int MAXD = 640;
  localparam int T    = 3;
  localparam int DW   = $clog2(MAXD+1);

  logic          clk_i = 1'b0;
  logic          reset_i, flush_i, valid_i, ready_i;
  logic          ready_o, valid_o, primed_o;
  logic [DW-1:0] delay_i;
  logic [W-1:0]  data_i;
  logic [T*W-1:0] data_o;

  always #5 clk_i = ~clk_i;

  line_buffer_taps #(.width_p(W), .max_delay_p(MAXD), .taps_p(T)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .flush_i (flush_i),
    .delay_i (delay_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .data_o  (data_o),
    .ready_i (ready_i),
    .primed_o(primed_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: list of pixels accepted since the last reset/flush.
  logic [W-1:0]   hist[$];
  int             d_m = 1;
  logic           exp_vld = 1'b0;
  logic           exp_primed = 1'b0;
  logic [T*W-1:0] exp_dat = '0;
  logic           last_acc;
  int             dut_pops;
  logic [W-1:0]   first_px;

  function automatic int clampd(input int x);
    if (x == 0) return 1;
    if (x > MAXD) return MAXD;
    return x;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check ready, clock, advance model, check outputs.
  task automatic step(input string tag, input logic rs, input logic fl, input logic v,
                      input logic r, input logic [W-1:0] px, input int dly);
    logic exp_rdy;
    int   n;
    reset_i = rs; flush_i = fl; valid_i = v; ready_i = r; data_i = px;
    delay_i = DW'(dly);
    #1;
    exp_rdy = !rs && !fl && (!exp_vld || r);
    chk({tag, "_rdy"}, 64'(ready_o), 64'(exp_rdy));
    if (valid_o === 1'b1 && r) dut_pops++;
    last_acc = v && exp_rdy;
    @(posedge clk_i);
    #1;
    if (rs) begin
      hist.delete();
      d_m = clampd(dly);
      exp_vld = 1'b0; exp_dat = '0; exp_primed = 1'b0;
    end else if (fl) begin
      hist.delete();
      d_m = clampd(dly);
      exp_primed = 1'b0;
      if (r) exp_vld = 1'b0;
    end else if (last_acc) begin
      hist.push_back(px);
      n = hist.size();
      exp_dat = '0;
      for (int k = 0; k < T; k++)
        if (n - 1 >= k * d_m) exp_dat[k*W +: W] = hist[n - 1 - k * d_m];
      exp_primed = (n >= (T - 1) * d_m);
      exp_vld = 1'b1;
    end else if (r) begin
      exp_vld = 1'b0;
    end
    chk({tag, "_vld"}, 64'(valid_o), 64'(exp_vld));
    chk({tag, "_dat"}, 64'(data_o), 64'(exp_dat));
    chk({tag, "_primed"}, 64'(primed_o), 64'(exp_primed));
  endtask

  initial begin
    int i;
    int c;
    logic [W-1:0] px;

    // 1: delay 4, stream 1..12 at full rate
    step("t1_reset", 1, 0, 0, 1, 0, 4);
    step("t1_reset", 1, 0, 0, 1, 0, 4);
    for (int j = 1; j <= 12; j++) step("t1_stream", 0, 0, 1, 1, W'(j), 4);
    step("t1_drain", 0, 0, 0, 1, 0, 4);

    // 2: same stream with ready toggling; count pops seen on the DUT
    step("t2_reset", 1, 0, 0, 1, 0, 4);
    dut_pops = 0;
    i = 1;
    c = 0;
    while (i <= 12 && c < 100) begin
      step("t2_stall", 0, 0, 1, (c % 2) == 0, W'(i), 4);
      if (last_acc) i++;
      c++;
    end
    step("t2_drain", 0, 0, 0, 1, 0, 4);
    step("t2_drain", 0, 0, 0, 1, 0, 4);
    chk("t2_pops", 64'(dut_pops), 64'(12));

    // random valid/ready/data traffic
    for (int j = 0; j < 300; j++)
      step("rand", 0, 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
           W'($urandom), 4);

    // 3: maximum line length, 2*max+1 pixels
    step("t3_reset", 1, 0, 0, 1, 0, MAXD);
    for (int j = 0; j < 2 * MAXD + 1; j++) begin
      px = W'($urandom);
      if (j == 0) first_px = px;
      step("t3_stream", 0, 0, 1, 1, px, MAXD);
    end
    chk("t3_last_tap2", 64'(data_o[2*W +: W]), 64'(first_px));
    chk("t3_last_primed", 64'(primed_o), 64'(1));

    // out-of-range line length clamps to max via flush
    step("clamp_flush", 0, 1, 0, 1, 0, 1000);
    for (int j = 0; j < MAXD + 1; j++) begin
      px = W'($urandom);
      if (j == 0) first_px = px;
      step("clamp_stream", 0, 0, 1, 1, px, 0);
    end
    chk("clamp_tap1", 64'(data_o[W +: W]), 64'(first_px));
    chk("clamp_tap2", 64'(data_o[2*W +: W]), 64'(0));

    // 4: mid-stream flush 4 -> 2 with a pending beat
    step("t4_reset", 1, 0, 0, 1, 0, 4);
    for (int j = 0; j < 6; j++) step("t4_pre", 0, 0, 1, 1, W'($urandom), 4);
    step("t4_hold", 0, 0, 1, 0, 8'haa, 4);
    step("t4_flush", 0, 1, 1, 0, 8'hbb, 2);
    step("t4_pop", 0, 0, 0, 1, 0, 7);
    for (int j = 0; j < 6; j++) step("t4_post", 0, 0, 1, 1, W'($urandom), 9);

    // 5: delay 0 at reset behaves as delay 1
    step("t5_reset", 1, 0, 0, 1, 0, 0);
    for (int j = 1; j <= 6; j++) step("t5_stream", 0, 0, 1, 1, W'(j + 16), 0);

    // 6: reset while an output beat is stalled
    step("t6_reset", 1, 0, 0, 1, 0, 2);
    for (int j = 0; j < 5; j++) step("t6_stream", 0, 0, 1, 1, W'($urandom), 2);
    step("t6_stall", 0, 0, 1, 0, 8'h55, 2);
    step("t6_midreset", 1, 0, 1, 0, 8'h66, 2);
    step("t6_after", 0, 0, 0, 0, 0, 2);
    step("t6_restart", 0, 0, 1, 1, 8'h77, 2);
    step("t6_restart", 0, 0, 1, 1, 8'h78, 2);
    step("t6_restart", 0, 0, 1, 1, 8'h79, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
